// File: rtl/maj_fold_seq.sv
// Folded N-input threshold/majority evaluator: one K-bit popcount slice reused over ceil(N/K) cycles.
// Optional early decision exit is enabled by defining MAJ_FOLD_EARLY_EXIT_EN.
`timescale 1ns/1ps

module maj_fold_seq #(
    parameter int N      = 27,
    parameter int K      = 9,
    parameter int THRESH = (N + 1) / 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               in_vec,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       y,
    output logic [$clog2(N+1)-1:0]     count,
    output logic                       busy
);

    localparam int CW    = $clog2(N + 1);
    localparam int FOLDS = (N + K - 1) / K;
    localparam int FW    = (FOLDS > 1) ? $clog2(FOLDS) : 1;

    localparam logic [CW-1:0] THR = CW'(THRESH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    sh_q;
    logic [CW-1:0]   acc_q;
    logic [FW-1:0]   fold_q;
    logic [CW-1:0]   y_cnt_q;
    logic            y_q;

    logic [CW-1:0]   fold_pop;
    logic [CW-1:0]   acc_next;
    logic            last_fold;
    logic            done_now;
    logic            accept;
    logic            finish;

    // Popcount of the lowest K bits of the shift register; padding bits are already zero.
    always_comb begin
        fold_pop = '0;
        for (int i = 0; i < K; i++) begin
            fold_pop = fold_pop + CW'(sh_q[i]);
        end
    end

    assign acc_next  = acc_q + fold_pop;
    assign last_fold = (fold_q == FW'(FOLDS - 1));

`ifdef MAJ_FOLD_EARLY_EXIT_EN
    localparam logic [CW-1:0] KC    = CW'(K);
    localparam logic [CW:0]   THR_W = (CW+1)'(THRESH);

    logic [CW-1:0] rem_q;
    logic [CW-1:0] rem_next;

    // rem_q counts input bits not yet folded into the accumulator.
    assign rem_next = (rem_q > KC) ? (rem_q - KC) : '0;
    assign done_now = last_fold || (acc_next >= THR) ||
                      (({1'b0, acc_next} + {1'b0, rem_next}) < THR_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
        end else if (accept) begin
            rem_q <= CW'(N);
        end else if (state_q == RUN) begin
            rem_q <= rem_next;
        end
    end
`else
    assign done_now = last_fold;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (done_now) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath; result registers are only written when a fold sequence finishes, so they hold after the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q    <= '0;
            acc_q   <= '0;
            fold_q  <= '0;
            y_q     <= 1'b0;
            y_cnt_q <= '0;
        end else begin
            if (accept) begin
                sh_q   <= in_vec;
                acc_q  <= '0;
                fold_q <= '0;
            end else if (state_q == RUN) begin
                sh_q   <= sh_q >> K;
                acc_q  <= acc_next;
                fold_q <= fold_q + 1'b1;
            end
            if (finish) begin
                y_q     <= (acc_next >= THR);
                y_cnt_q <= acc_next;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign y         = y_q;
    assign count     = y_cnt_q;

endmodule

// File: tb/tb_maj_fold_seq.sv
// Self-checking bench for maj_fold_seq: default 27/9 instance, a 10/4 non-multiple instance and a 9/3 exhaustive instance.
// Expectations follow the early-exit behaviour when MAJ_FOLD_EARLY_EXIT_EN is defined.
`timescale 1ns/1ps

module tb_maj_fold_seq;

    typedef struct {
        int   dut;
        logic y;
        int   cnt;
        int   lat;
    } exp_t;

    typedef struct {
        logic [26:0] vec;
        logic        y;
        int          cnt;
        int          hold;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic        iv   [3];
    logic        ordy [3];
    logic        ir   [3];
    logic        ov   [3];
    logic        yy   [3];
    logic        bz   [3];
    logic [4:0]  cnt  [3];

    logic [26:0] v0;
    logic [9:0]  v1;
    logic [8:0]  v2;
    logic [4:0]  c0;
    logic [3:0]  c1;
    logic [3:0]  c2;

    assign cnt[0] = c0;
    assign cnt[1] = {1'b0, c1};
    assign cnt[2] = {1'b0, c2};

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    maj_fold_seq u0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_vec(v0),
        .out_valid(ov[0]), .out_ready(ordy[0]), .y(yy[0]), .count(c0), .busy(bz[0])
    );

    maj_fold_seq #(.N(10), .K(4), .THRESH(6)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_vec(v1),
        .out_valid(ov[1]), .out_ready(ordy[1]), .y(yy[1]), .count(c1), .busy(bz[1])
    );

    maj_fold_seq #(.N(9), .K(3)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_vec(v2),
        .out_valid(ov[2]), .out_ready(ordy[2]), .y(yy[2]), .count(c2), .busy(bz[2])
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: full popcount decides y; with early exit the fold where the outcome is settled gives count and latency.
    function automatic exp_t model(input int d, input int n, input int k, input int th,
                                   input logic [26:0] v);
        exp_t e;
        int   pop;
        int   folds;
        pop = 0;
        for (int i = 0; i < n; i++) pop += int'(v[i]);
        folds = (n + k - 1) / k;
        e.dut = d;
        e.y   = (pop >= th);
        e.cnt = pop;
        e.lat = folds;
`ifdef MAJ_FOLD_EARLY_EXIT_EN
        begin
            int acc;
            acc = 0;
            for (int f = 0; f < folds; f++) begin
                int rem;
                for (int i = f * k; i < f * k + k && i < n; i++) acc += int'(v[i]);
                rem = n - (f + 1) * k;
                if (rem < 0) rem = 0;
                if (acc >= th || acc + rem < th || f == folds - 1) begin
                    e.cnt = acc;
                    e.lat = f + 1;
                    break;
                end
            end
        end
`endif
        return e;
    endfunction

    task automatic checkOutput(input int d, input int lat, input int hold);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check("dut_id", d, e.dut);
        check("y", int'(yy[d]), int'(e.y));
        check("count", int'(cnt[d]), e.cnt);
        check("latency", lat, e.lat);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_out_valid", int'(ov[d]), 1);
            check("hold_y", int'(yy[d]), int'(e.y));
            check("hold_count", int'(cnt[d]), e.cnt);
            check("hold_in_ready", int'(ir[d]), 0);
        end
        ordy[d] = 1'b1;
        @(posedge clk); #1;
        check("post_out_valid", int'(ov[d]), 0);
        check("post_in_ready", int'(ir[d]), 1);
        check("post_busy", int'(bz[d]), 0);
        check("post_y_kept", int'(yy[d]), int'(e.y));
        check("post_count_kept", int'(cnt[d]), e.cnt);
    endtask

    task automatic applyStimulus(input int d, input logic [26:0] v, input exp_t e, input int hold);
        int guard;
        int lat;
        ordy[d] = (hold == 0);
        guard = 0;
        while (!ir[d] && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!ir[d]) begin
            check("accept_wait", 0, 1);
            return;
        end
        case (d)
            0:       v0 = v;
            1:       v1 = v[9:0];
            default: v2 = v[8:0];
        endcase
        iv[d] = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        iv[d] = 1'b0;
        check("run_in_ready", int'(ir[d]), 0);
        lat = 0;
        while (!ov[d] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ov[d]) begin
            check("result_wait", 0, 1);
            void'(exp_q.pop_front());
            return;
        end
        checkOutput(d, lat, hold);
    endtask

    vec_t tbl [7];

    initial begin
        exp_t e;
        int   seen;

        for (int i = 0; i < 3; i++) begin
            iv[i]   = 1'b0;
            ordy[i] = 1'b0;
        end
        v0 = '0;
        v1 = '0;
        v2 = '0;

        tbl[0] = '{vec: {9'h00F, 9'h01F, 9'h01F}, y: 1'b1, cnt: 14, hold: 5};
        tbl[1] = '{vec: {9'h007, 9'h01F, 9'h01F}, y: 1'b0, cnt: 13, hold: 1};
        tbl[2] = '{vec: 27'h7FFFFFF,              y: 1'b1, cnt: 27, hold: 0};
        tbl[3] = '{vec: 27'h0000000,              y: 1'b0, cnt: 0,  hold: 0};
        tbl[4] = '{vec: 27'h5555555,              y: 1'b1, cnt: 14, hold: 2};
        tbl[5] = '{vec: 27'h0001FFF,              y: 1'b0, cnt: 13, hold: 0};
        tbl[6] = '{vec: 27'h7FFE000,              y: 1'b1, cnt: 14, hold: 0};

        #12;
        check("reset_in_ready", int'(ir[0]), 1);
        check("reset_out_valid", int'(ov[0]), 0);
        check("reset_y", int'(yy[0]), 0);
        check("reset_count", int'(cnt[0]), 0);
        check("reset_busy", int'(bz[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
`ifdef MAJ_FOLD_EARLY_EXIT_EN
            e = model(0, 27, 9, 14, tbl[i].vec);
`else
            e.dut = 0;
            e.cnt = tbl[i].cnt;
            e.lat = 3;
`endif
            e.y = tbl[i].y;
            applyStimulus(0, tbl[i].vec, e, tbl[i].hold);
        end

        // Asynchronous reset in the middle of a fold sequence must drop the vector without a result.
        ordy[0] = 1'b0;
        v0 = 27'h7FFFFFF;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("midrun_reset_in_ready", int'(ir[0]), 1);
        check("midrun_reset_out_valid", int'(ov[0]), 0);
        check("midrun_reset_count", int'(cnt[0]), 0);
        check("midrun_reset_busy", int'(bz[0]), 0);
        check("midrun_reset_y", int'(yy[0]), 0);
        #2;
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ov[0]) seen++;
        end
        check("no_result_after_reset", seen, 0);

        e.dut = 1;
        e.y   = 1'b1;
        e.cnt = 6;
        e.lat = 3;
        applyStimulus(1, 27'(10'b11_0000_1111), e, 1);
        e = model(1, 10, 4, 6, 27'(10'b11_1111_0000));
        applyStimulus(1, 27'(10'b11_1111_0000), e, 0);

        for (int v = 0; v < 512; v++) begin
            e = model(2, 9, 3, 5, 27'(v));
            applyStimulus(2, 27'(v), e, 0);
        end

        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
